// File: rtl/neuron_layer.sv
// Register file holding every neuron value of one fully-connected layer.
// One addressed write per clock; all neurons exposed in parallel, neuron 0 in the MSBs.
module neuron_layer #(
    parameter int SIZE     = 16,
    parameter int LAYER_SZ = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_en,
    input  logic [SIZE-1:0]          load_value,
    input  logic [SIZE-1:0]          load_address,
    output logic [LAYER_SZ*SIZE-1:0] values
);

    logic [SIZE-1:0] neuron_q [LAYER_SZ];
    logic [SIZE-1:0] neuron_d [LAYER_SZ];

    // Next-state: only the neuron whose index equals the address is written,
    // so out-of-range addresses match nothing and the write is dropped.
    always_comb begin
        for (int k = 0; k < LAYER_SZ; k++) begin
            if (load_en && (load_address == SIZE'(k))) begin
                neuron_d[k] = load_value;
            end else begin
                neuron_d[k] = neuron_q[k];
            end
        end
    end

    // Neuron storage with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LAYER_SZ; k++) begin
                neuron_q[k] <= {SIZE{1'b0}};
            end
        end else begin
            for (int k = 0; k < LAYER_SZ; k++) begin
                neuron_q[k] <= neuron_d[k];
            end
        end
    end

    // Pack registers onto the output bus, neuron 0 in the most-significant slot.
    always_comb begin
        values = {(LAYER_SZ*SIZE){1'b0}};
        for (int k = 0; k < LAYER_SZ; k++) begin
            values[(LAYER_SZ-k)*SIZE-1 -: SIZE] = neuron_q[k];
        end
    end

endmodule

// File: tb/tb_neuron_layer.sv
// Self-checking bench for neuron_layer: default 16x2 instance plus an 8x4 instance
// for the packing sweep; expected bus values flow through a scoreboard queue.
module tb_neuron_layer;

    logic        clk;
    logic        reset;
    logic        load_en;
    logic [15:0] load_value;
    logic [15:0] load_address;
    logic [31:0] values;

    logic        load_en2;
    logic [7:0]  load_value2;
    logic [7:0]  load_address2;
    logic [31:0] values2;

    logic [31:0] exp_q [$];
    logic [31:0] exp_v;
    logic [15:0] model [2];
    int          n_checks;
    int          n_fail;

    neuron_layer #(.SIZE(16), .LAYER_SZ(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_en      (load_en),
        .load_value   (load_value),
        .load_address (load_address),
        .values       (values)
    );

    neuron_layer #(.SIZE(8), .LAYER_SZ(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .load_en      (load_en2),
        .load_value   (load_value2),
        .load_address (load_address2),
        .values       (values2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
        $fatal(1, "watchdog");
    end

    // Drive inputs at the falling edge, then sample 1 after the next rising edge.
    task automatic drive_cycle(input logic en, input logic [15:0] val, input logic [15:0] addr);
        @(negedge clk);
        load_en      = en;
        load_value   = val;
        load_address = addr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            model[k] = 16'($urandom);
            drive_cycle(1'b1, model[k], 16'(k));
        end
        exp_q.push_back({model[0], model[1]});
        exp_v = exp_q.pop_front();
        n_checks++;
        if (values !== exp_v) begin
            n_fail++;
            $display("FAIL reset_prefill: got %h expected %h", values, exp_v);
        end
        @(negedge clk);
        load_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        exp_q.push_back(32'h0000_0000);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (values !== exp_v) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", values, exp_v);
        end
        exp_q.push_back(32'h0000_0000);
        drive_cycle(1'b1, 16'h5555, 16'h0000);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (values !== exp_v) begin
            n_fail++;
            $display("FAIL reset_held_write: got %h expected %h", values, exp_v);
        end
        @(negedge clk);
        reset   = 1'b1;
        load_en = 1'b0;
        exp_q.push_back(32'h0000_0000);
        drive_cycle(1'b0, 16'hFFFF, 16'h0001);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (values !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", values, exp_v);
        end
    endtask

    task automatic test_sequential();
        logic [15:0] vals  [4] = '{16'h8000, 16'h0008, 16'h1111, 16'h0008};
        logic [15:0] addrs [4] = '{16'h0000, 16'h0001, 16'h0001, 16'h0000};
        logic [31:0] exps  [4] = '{32'h8000_0000, 32'h8000_0008, 32'h8000_1111, 32'h0008_1111};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exps[i]);
            drive_cycle(1'b1, vals[i], addrs[i]);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (values !== exp_v) begin
                n_fail++;
                $display("FAIL seq_load_%0d: got %h expected %h", i, values, exp_v);
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h0008_1111);
            drive_cycle(1'b0, 16'hFFFF, 16'h0000);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (values !== exp_v) begin
                n_fail++;
                $display("FAIL hold_%0d: got %h expected %h", i, values, exp_v);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] addrs [3] = '{16'h0002, 16'hFFFF, 16'h0001};
        logic [31:0] exps  [3] = '{32'h0008_1111, 32'h0008_1111, 32'h0008_ABCD};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exps[i]);
            drive_cycle(1'b1, 16'hABCD, addrs[i]);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (values !== exp_v) begin
                n_fail++;
                $display("FAIL out_of_range_%0d: got %h expected %h", i, values, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        load_en      = 1'b1;
        load_value   = 16'h1234;
        load_address = 16'h0000;
        reset        = 1'b0;
        #1;
        exp_q.push_back(32'h0000_0000);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (values !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h expected %h", values, exp_v);
        end
        @(posedge clk);
        #1;
        exp_q.push_back(32'h0000_0000);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (values !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid_write_lost: got %h expected %h", values, exp_v);
        end
        @(negedge clk);
        reset   = 1'b1;
        load_en = 1'b0;
        exp_q.push_back(32'h1234_0000);
        drive_cycle(1'b1, 16'h1234, 16'h0000);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (values !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid_after: got %h expected %h", values, exp_v);
        end
    endtask

    task automatic test_param_sweep();
        logic [31:0] exps [4] = '{32'h0100_0000, 32'h0102_0000, 32'h0102_0300, 32'h0102_0304};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            load_en2      = 1'b1;
            load_value2   = (k < 4) ? 8'(k + 1) : 8'hEE;
            load_address2 = (k < 4) ? 8'(k) : ((k == 4) ? 8'h04 : 8'hFF);
            exp_q.push_back(exps[(k < 4) ? k : 3]);
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (values2 !== exp_v) begin
                n_fail++;
                $display("FAIL sweep_%0d: got %h expected %h", k, values2, exp_v);
            end
        end
        @(negedge clk);
        load_en2 = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b0;
        load_en       = 1'b0;
        load_value    = 16'h0000;
        load_address  = 16'h0000;
        load_en2      = 1'b0;
        load_value2   = 8'h00;
        load_address2 = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_sequential();
        test_hold();
        test_out_of_range();
        test_reset_mid();
        test_param_sweep();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
